// File: rtl/vga_timing_if.sv
// VGA raster timing bundle: the timing generator drives it, the drawing logic consumes it.
// The widths must equal $clog2 of the whole line and whole frame used by the generator.
interface vga_timing_if #(
  parameter int H_ADDR_WIDTH = 10,
  parameter int V_ADDR_WIDTH = 10
);
  logic                    pix_stb;
  logic [H_ADDR_WIDTH-1:0] sx;
  logic [V_ADDR_WIDTH-1:0] sy;
  logic                    hsync;
  logic                    vsync;
  logic                    display_enabled;
  logic                    line_stb;
  logic                    frame_stb;

  modport master (
    output pix_stb, sx, sy, hsync, vsync, display_enabled, line_stb, frame_stb
  );

  modport slave (
    input  pix_stb, sx, sy, hsync, vsync, display_enabled, line_stb, frame_stb
  );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator: clock-divided pixel strobe, sx/sy counters, sync pulses,
// visible-area flag and line/frame strobes, all registered and aligned with the counters.
module vga_timing #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC_PULSE   = 96,
  parameter int H_BACK_PORCH   = 48,
  parameter int V_VISIBLE_AREA = 480,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC_PULSE   = 2,
  parameter int V_BACK_PORCH   = 33,
  parameter bit H_SYNC_POL     = 1'b0,
  parameter bit V_SYNC_POL     = 1'b0,
  parameter int CLK_DIV        = 4
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);
  localparam int H_WHOLE_LINE = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_WHOLE_LINE = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
  localparam int H_ADDR_WIDTH = $clog2(H_WHOLE_LINE);
  localparam int V_ADDR_WIDTH = $clog2(V_WHOLE_LINE);
  localparam int DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_ADDR_WIDTH-1:0] H_LAST   = H_ADDR_WIDTH'(H_WHOLE_LINE - 1);
  localparam logic [V_ADDR_WIDTH-1:0] V_LAST   = V_ADDR_WIDTH'(V_WHOLE_LINE - 1);
  localparam logic [V_ADDR_WIDTH-1:0] V_BLANK  = V_ADDR_WIDTH'(V_VISIBLE_AREA);

  // Region bounds kept at 32 bits so an end bound equal to the whole line cannot wrap.
  localparam logic [31:0] H_VIS_END  = 32'(H_VISIBLE_AREA);
  localparam logic [31:0] H_SYNC_BEG = 32'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [31:0] H_SYNC_END = 32'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [31:0] V_VIS_END  = 32'(V_VISIBLE_AREA);
  localparam logic [31:0] V_SYNC_BEG = 32'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [31:0] V_SYNC_END = 32'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);

  logic [DIV_W-1:0]        div_cnt;
  logic                    wrap;
  logic [H_ADDR_WIDTH-1:0] sx_nxt;
  logic [V_ADDR_WIDTH-1:0] sy_nxt;
  logic [31:0]             sx_w;
  logic [31:0]             sy_w;
  logic                    hs_act;
  logic                    vs_act;
  logic                    de_nxt;
  logic                    line_nxt;
  logic                    frame_nxt;

  // Next raster position: counters only move on the edge that raises pix_stb.
  always_comb begin
    wrap   = (div_cnt == DIV_LAST);
    sx_nxt = vga.sx;
    sy_nxt = vga.sy;
    if (wrap) begin
      if (vga.sx == H_LAST) begin
        sx_nxt = '0;
        sy_nxt = (vga.sy == V_LAST) ? '0 : vga.sy + 1'b1;
      end else begin
        sx_nxt = vga.sx + 1'b1;
      end
    end
    sx_w      = 32'(sx_nxt);
    sy_w      = 32'(sy_nxt);
    hs_act    = (sx_w >= H_SYNC_BEG) && (sx_w < H_SYNC_END);
    vs_act    = (sy_w >= V_SYNC_BEG) && (sy_w < V_SYNC_END);
    de_nxt    = (sx_w < H_VIS_END) && (sy_w < V_VIS_END);
    line_nxt  = wrap && (sx_nxt == '0);
    frame_nxt = line_nxt && (sy_nxt == V_BLANK);
  end

  // Register stage: flags derive from the next counters so they land with the pixel they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt             <= '0;
      vga.pix_stb         <= 1'b0;
      vga.sx              <= H_LAST;
      vga.sy              <= V_LAST;
      vga.hsync           <= ~H_SYNC_POL;
      vga.vsync           <= ~V_SYNC_POL;
      vga.display_enabled <= 1'b0;
      vga.line_stb        <= 1'b0;
      vga.frame_stb       <= 1'b0;
    end else begin
      div_cnt             <= wrap ? '0 : div_cnt + 1'b1;
      vga.pix_stb         <= wrap;
      vga.sx              <= sx_nxt;
      vga.sy              <= sy_nxt;
      vga.hsync           <= hs_act ? H_SYNC_POL : ~H_SYNC_POL;
      vga.vsync           <= vs_act ? V_SYNC_POL : ~V_SYNC_POL;
      vga.display_enabled <= de_nxt;
      vga.line_stb        <= line_nxt;
      vga.frame_stb       <= frame_nxt;
    end
  end
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (small CLK_DIV=4, small CLK_DIV=1 positive sync, defaults)
// checked every cycle against a closed-form raster model through per-instance expectation queues.
module tb_vga_timing;
  typedef struct packed {
    logic [15:0] sx;
    logic [15:0] sy;
    logic        pix;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
  } obs_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   k;
  obs_t qa[$];
  obs_t qb[$];
  obs_t qc[$];

  vga_timing_if #(.H_ADDR_WIDTH(4),  .V_ADDR_WIDTH(4))  ifa ();
  vga_timing_if #(.H_ADDR_WIDTH(5),  .V_ADDR_WIDTH(4))  ifb ();
  vga_timing_if #(.H_ADDR_WIDTH(10), .V_ADDR_WIDTH(10)) ifc ();

  vga_timing #(
    .H_VISIBLE_AREA(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
    .V_VISIBLE_AREA(6), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CLK_DIV(4)
  ) dut_a (.clk(clk), .rst(rst), .vga(ifa));

  vga_timing #(
    .H_VISIBLE_AREA(10), .H_FRONT_PORCH(2), .H_SYNC_PULSE(4), .H_BACK_PORCH(3),
    .V_VISIBLE_AREA(5),  .V_FRONT_PORCH(2), .V_SYNC_PULSE(1), .V_BACK_PORCH(2),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(1)
  ) dut_b (.clk(clk), .rst(rst), .vga(ifb));

  vga_timing dut_c (.clk(clk), .rst(rst), .vga(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Closed form: kk = edges since the last reset edge; pixel n = kk/d begins at edge n*d.
  function automatic obs_t model(int kk, int d, int hv, int hf, int hs, int hb,
                                 int vv, int vf, int vs, int vb, bit hp, bit vp);
    int   hw, vw, l, x, y;
    bit   pix;
    obs_t e;
    hw = hv + hf + hs + hb;
    vw = vv + vf + vs + vb;
    if (kk < d) begin
      x = hw - 1; y = vw - 1; pix = 1'b0;
    end else begin
      l = (kk / d - 1) % (hw * vw);
      x = l % hw; y = l / hw; pix = (kk % d == 0);
    end
    e.sx  = 16'(x);
    e.sy  = 16'(y);
    e.pix = pix;
    e.hs  = (x >= hv + hf && x < hv + hf + hs) ? hp : !hp;
    e.vs  = (y >= vv + vf && y < vv + vf + vs) ? vp : !vp;
    e.de  = (x < hv) && (y < vv);
    e.ls  = pix && (x == 0);
    e.fs  = pix && (x == 0) && (y == vv);
    return e;
  endfunction

  // One clock: push expectations for the coming edge, then pop and score on the falling edge.
  task automatic tick();
    obs_t e, o;
    if (rst === 1'b0) k = 0; else k++;
    qa.push_back(model(k, 4, 8, 2, 3, 2, 6, 1, 2, 1, 1'b0, 1'b0));
    qb.push_back(model(k, 1, 10, 2, 4, 3, 5, 2, 1, 2, 1'b1, 1'b1));
    qc.push_back(model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    e = qa.pop_front();
    o = {16'(ifa.sx), 16'(ifa.sy), ifa.pix_stb, ifa.hsync, ifa.vsync,
         ifa.display_enabled, ifa.line_stb, ifa.frame_stb};
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL sb_a k=%0d got=%h expected=%h", k, o, e);
    end
    e = qb.pop_front();
    o = {16'(ifb.sx), 16'(ifb.sy), ifb.pix_stb, ifb.hsync, ifb.vsync,
         ifb.display_enabled, ifb.line_stb, ifb.frame_stb};
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL sb_b k=%0d got=%h expected=%h", k, o, e);
    end
    e = qc.pop_front();
    o = {16'(ifc.sx), 16'(ifc.sy), ifc.pix_stb, ifc.hsync, ifc.vsync,
         ifc.display_enabled, ifc.line_stb, ifc.frame_stb};
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL sb_c k=%0d got=%h expected=%h", k, o, e);
    end
    checks++;
    if ((((ifa.line_stb | ifa.frame_stb) & ~ifa.pix_stb) |
         ((ifb.line_stb | ifb.frame_stb) & ~ifb.pix_stb) |
         ((ifc.line_stb | ifc.frame_stb) & ~ifc.pix_stb)) !== 1'b0) begin
      failures++;
      $display("FAIL strobe_without_pix k=%0d got=1 expected=0", k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({ifc.sx, ifc.sy, ifc.hsync, ifc.vsync, ifc.pix_stb, ifc.line_stb, ifc.frame_stb,
           ifc.display_enabled} !== {10'd799, 10'd524, 1'b1, 1'b1, 4'b0000}) begin
        failures++;
        $display("FAIL reset_values sx=%0d sy=%0d hs=%b vs=%b expected 799 524 1 1", ifc.sx, ifc.sy,
                 ifc.hsync, ifc.vsync);
      end
    end
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (ifc.pix_stb !== (i == 4)) begin
        failures++;
        $display("FAIL first_pix edge=%0d got=%b", i, ifc.pix_stb);
      end
    end
    checks++;
    if ({ifc.line_stb, ifc.display_enabled, ifc.sx, ifc.sy} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
      failures++;
      $display("FAIL first_pixel got ls=%b de=%b sx=%0d sy=%0d expected 1 1 0 0",
               ifc.line_stb, ifc.display_enabled, ifc.sx, ifc.sy);
    end
  endtask

  task automatic test_horizontal();
    int hs_low, ls_cnt, de_fall_sx;
    logic de_prev;
    hs_low = 0; ls_cnt = 0; de_fall_sx = -1; de_prev = ifc.display_enabled;
    for (int i = 0; i < 3200; i++) begin
      tick();
      if (ifc.hsync === 1'b0) hs_low++;
      if (ifc.line_stb === 1'b1) ls_cnt++;
      if (de_prev === 1'b1 && ifc.display_enabled === 1'b0 && de_fall_sx < 0) de_fall_sx = int'(ifc.sx);
      de_prev = ifc.display_enabled;
    end
    checks++;
    if (hs_low != 384) begin
      failures++;
      $display("FAIL hsync_width got=%0d expected=384", hs_low);
    end
    checks++;
    if (de_fall_sx != 640) begin
      failures++;
      $display("FAIL de_fall_sx got=%0d expected=640", de_fall_sx);
    end
    checks++;
    if ({ls_cnt, 22'(ifc.sx), 22'(ifc.sy), ifc.line_stb} !== {32'd1, 22'd0, 22'd1, 1'b1}) begin
      failures++;
      $display("FAIL line_wrap got ls_cnt=%0d sx=%0d sy=%0d expected 1 0 1", ls_cnt, ifc.sx, ifc.sy);
    end
  endtask

  task automatic test_vertical_frame();
    int fa_last, fb_last, fa_cnt, fb_cnt, bad_vs, vs_low, bad_wrap, prev_sy;
    fa_last = -1; fb_last = -1; fa_cnt = 0; fb_cnt = 0; bad_vs = 0; vs_low = 0; bad_wrap = 0;
    prev_sy = int'(ifa.sy);
    for (int i = 0; i < 1250; i++) begin
      tick();
      if (ifa.vsync === 1'b0) begin
        vs_low++;
        if (ifa.sy < 7 || ifa.sy > 8) bad_vs++;
      end
      if (ifa.pix_stb && ifa.sy == 0 && prev_sy != 0 && (prev_sy != 9 || ifa.sx != 0)) bad_wrap++;
      prev_sy = int'(ifa.sy);
      if (ifa.frame_stb === 1'b1) begin
        if (fa_last >= 0) begin
          checks++;
          if (k - fa_last != 600) begin
            failures++;
            $display("FAIL frame_period_a got=%0d expected=600", k - fa_last);
          end
        end
        fa_last = k; fa_cnt++;
      end
      if (ifb.frame_stb === 1'b1) begin
        if (fb_last >= 0) begin
          checks++;
          if (k - fb_last != 190) begin
            failures++;
            $display("FAIL frame_period_b got=%0d expected=190", k - fb_last);
          end
        end
        fb_last = k; fb_cnt++;
      end
    end
    checks++;
    if (fa_cnt != 2 || fb_cnt < 6) begin
      failures++;
      $display("FAIL frame_count got a=%0d b=%0d expected a=2 b>=6", fa_cnt, fb_cnt);
    end
    checks++;
    if (bad_vs != 0 || vs_low != 240) begin
      failures++;
      $display("FAIL vsync_window got bad=%0d low=%0d expected 0 240", bad_vs, vs_low);
    end
    checks++;
    if (bad_wrap != 0) begin
      failures++;
      $display("FAIL sy_wrap got bad=%0d expected=0", bad_wrap);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    int fs_cnt;
    found = 1'b0;
    for (int i = 0; i < 700 && !found; i++) begin
      tick();
      if (ifa.sx == 5 && ifa.sy == 4) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_frame_wait got=timeout expected=(5,4)");
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if ({ifa.sx, ifa.sy, ifa.pix_stb, ifa.hsync, ifa.vsync, ifa.display_enabled, ifa.line_stb,
         ifa.frame_stb} !== {4'd14, 4'd9, 1'b0, 1'b1, 1'b1, 3'b000}) begin
      failures++;
      $display("FAIL mid_reset_state got sx=%0d sy=%0d expected 14 9", ifa.sx, ifa.sy);
    end
    fs_cnt = 0;
    while (k < 364) begin
      tick();
      if (ifa.frame_stb === 1'b1) fs_cnt++;
    end
    checks++;
    if (fs_cnt != 1 || ifa.frame_stb !== 1'b1) begin
      failures++;
      $display("FAIL restart_frame got count=%0d last=%b expected 1 1", fs_cnt, ifa.frame_stb);
    end
  endtask

  task automatic test_clk_div1();
    int pix_low, bad_adv, bad_hs, prev_sx;
    pix_low = 0; bad_adv = 0; bad_hs = 0; prev_sx = int'(ifb.sx);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (ifb.pix_stb !== 1'b1) pix_low++;
      if (int'(ifb.sx) != (prev_sx + 1) % 19) bad_adv++;
      if (ifb.hsync !== (ifb.sx >= 12 && ifb.sx <= 15)) bad_hs++;
      prev_sx = int'(ifb.sx);
    end
    checks++;
    if (pix_low != 0) begin
      failures++;
      $display("FAIL div1_pix got_low=%0d expected=0", pix_low);
    end
    checks++;
    if (bad_adv != 0) begin
      failures++;
      $display("FAIL div1_advance got_bad=%0d expected=0", bad_adv);
    end
    checks++;
    if (bad_hs != 0) begin
      failures++;
      $display("FAIL div1_hsync got_bad=%0d expected=0", bad_hs);
    end
  endtask

  task automatic test_strobe_exclusivity();
    bit found;
    int ls_cnt, fs_cnt, de_cnt;
    found = (ifa.frame_stb === 1'b1);
    for (int i = 0; i < 700 && !found; i++) begin
      tick();
      if (ifa.frame_stb === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL frame_wait got=timeout expected=frame_stb");
    end
    ls_cnt = 0; fs_cnt = 0; de_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (ifa.line_stb === 1'b1) ls_cnt++;
      if (ifa.frame_stb === 1'b1) fs_cnt++;
      if (ifa.pix_stb === 1'b1 && ifa.display_enabled === 1'b1) de_cnt++;
    end
    checks++;
    if (ls_cnt != 10 || fs_cnt != 1) begin
      failures++;
      $display("FAIL frame_strobes got ls=%0d fs=%0d expected 10 1", ls_cnt, fs_cnt);
    end
    checks++;
    if (de_cnt != 48) begin
      failures++;
      $display("FAIL visible_pixels got=%0d expected=48", de_cnt);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    k = 0;
    rst = 1'b0;
    test_reset();
    test_horizontal();
    test_vertical_frame();
    test_reset_mid_frame();
    test_clk_div1();
    test_strobe_exclusivity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing.md
# vga_timing

Generates VGA raster timing for the display path: pixel-rate strobe, horizontal/vertical pixel counters, sync pulses, a visible-area flag, and line/frame strobes. Runs entirely on the system clock and derives the pixel rate by clock division. It sits directly upstream of the drawing logic, which consumes `sx`, `sy`, `display_enabled` and `frame_stb` to colour pixels and advance sprite/game state once per frame.

## Interface

**Parameters**

- `H_VISIBLE_AREA`, default 640: visible pixels per line.
- `H_FRONT_PORCH`, default 16: horizontal front porch, in pixels.
- `H_SYNC_PULSE`, default 96: hsync width, in pixels.
- `H_BACK_PORCH`, default 48: horizontal back porch, in pixels.
- `V_VISIBLE_AREA`, default 480: visible lines per frame.
- `V_FRONT_PORCH`, default 10: vertical front porch, in lines.
- `V_SYNC_PULSE`, default 2: vsync width, in lines.
- `V_BACK_PORCH`, default 33: vertical back porch, in lines.
- `H_SYNC_POL`, default 0: active level of hsync (0 = active-low).
- `V_SYNC_POL`, default 0: active level of vsync (0 = active-low).
- `CLK_DIV`, default 4: `clk` cycles per pixel; must be ≥1.
- Derived (localparam): `H_WHOLE_LINE` = sum of the four H parameters (800); `V_WHOLE_LINE` = sum of the four V parameters (525); `H_ADDR_WIDTH` = `$clog2(H_WHOLE_LINE)`; `V_ADDR_WIDTH` = `$clog2(V_WHOLE_LINE)`.

**Ports**

- `clk`, input, 1: the only clock.
- `rst`, input, 1: reset, synchronous, active-low.
- `pix_stb`, output, 1: one-`clk` pulse marking the first cycle of each pixel.
- `sx`, output, `H_ADDR_WIDTH`: current pixel column, 0..`H_WHOLE_LINE`-1.
- `sy`, output, `V_ADDR_WIDTH`: current line, 0..`V_WHOLE_LINE`-1.
- `hsync`, output, 1: horizontal sync, at polarity `H_SYNC_POL`.
- `vsync`, output, 1: vertical sync, at polarity `V_SYNC_POL`.
- `display_enabled`, output, 1: high when `sx < H_VISIBLE_AREA` and `sy < V_VISIBLE_AREA`.
- `line_stb`, output, 1: one-`clk` pulse when `sx` becomes 0.
- `frame_stb`, output, 1: one-`clk` pulse when (`sx`,`sy`) becomes (0,`V_VISIBLE_AREA`), i.e. the start of vertical blanking.

## Operation

- **Divider:**
  - `div_cnt` counts 0..`CLK_DIV`-1 and wraps.
  - `pix_stb` is registered and goes high on the edge where `div_cnt` wraps to 0.
  - `CLK_DIV`=1: `pix_stb` is held high every cycle after reset.
- **Counters:** they advance only on the edge that raises `pix_stb`.
  - `sx` = `H_WHOLE_LINE`-1 → `sx`=0 and `sy` increments.
  - `sy` = `V_WHOLE_LINE`-1 at the same point → `sy`=0.
  - Otherwise `sx` increments.
- **Registered outputs:** `hsync`, `vsync`, `display_enabled`, `line_stb` and `frame_stb` are all registered. They are computed from the next counter values, so they are always aligned with the `sx`/`sy` they describe.
- **hsync** is active for `H_VISIBLE_AREA+H_FRONT_PORCH` ≤ `sx` < `H_VISIBLE_AREA+H_FRONT_PORCH+H_SYNC_PULSE`, i.e. 656..751 at defaults.
- **vsync** is active for `V_VISIBLE_AREA+V_FRONT_PORCH` ≤ `sy` < `V_VISIBLE_AREA+V_FRONT_PORCH+V_SYNC_PULSE`, i.e. 490..491 at defaults.
- **Strobes:** `line_stb` and `frame_stb` are high only in a cycle where `pix_stb` is also high, for exactly one `clk` cycle.
- **Reset** (`rst`=0 at a rising edge), in any state including mid-line or mid-frame:
  - `div_cnt`=0.
  - `sx`=`H_WHOLE_LINE`-1 and `sy`=`V_WHOLE_LINE`-1, i.e. the last blank pixel.
  - `pix_stb`, `line_stb`, `frame_stb`, `display_enabled` = 0.
  - `hsync`, `vsync` = inactive (`~POL`).
- **Arithmetic:** all compares are unsigned at the counter width. Sums of parameters are evaluated as 32-bit constants, so there is no truncation.

## Timing

- **After reset release,** the first `pix_stb` is registered at the `CLK_DIV`-th rising edge. On that edge the outputs become `sx`=0, `sy`=0, `line_stb`=1, `display_enabled`=1.
  - The first frame therefore begins cleanly with no partial line.
- **Pixel period:** `CLK_DIV` cycles. `sx`, `sy` and the derived outputs are stable for all `CLK_DIV` cycles of a pixel.
- **Line period:** `H_WHOLE_LINE`×`CLK_DIV` = 3200 `clk` cycles at defaults.
- **Frame period:** `H_WHOLE_LINE`×`V_WHOLE_LINE`×`CLK_DIV` = 1,680,000 `clk` cycles at defaults.
- **`frame_stb` spacing:** exactly one frame period between pulses. The first pulse arrives 480×800×4 = 1,536,000 cycles after the first `pix_stb`.
- **Latency:** zero cycles between a counter value and its derived flags, since all are updated on the same edge.
- **Reset:** takes effect on the next edge, and no strobe is emitted in the reset cycle.

## Test plan

1. **Reset values:** hold `rst`=0 for 5 cycles, then release.
   - During reset: `sx`=799, `sy`=524, `hsync`=`vsync`=1, all strobes and `display_enabled` = 0.
   - On the 4th edge after release: `pix_stb`=`line_stb`=1, (0,0), `display_enabled`=1.
2. **Horizontal timing:** run one line.
   - `hsync`=0 for exactly `sx`=656..751, i.e. 384 `clk` cycles.
   - `display_enabled` drops at `sx`=640.
   - At `sx` 799→0: `sy` increments and `line_stb` pulses for 1 cycle.
3. **Vertical and frame timing:** run two frames.
   - `vsync`=0 only for `sy`=490..491.
   - `frame_stb` fires once per frame at (0,480), with pulses 1,680,000 cycles apart.
   - `sy` wraps 524→0 together with `sx` 799→0.
4. **Reset mid-frame:** assert `rst`=0 for 1 cycle at (300,200).
   - Next edge: counters at (799,524) and outputs inactive.
   - Timing then restarts exactly as in scenario 1, with no stray `frame_stb`.
5. **`CLK_DIV`=1 with `H_SYNC_POL`=`V_SYNC_POL`=1:**
   - `pix_stb` is constant 1 after the first edge.
   - `sx` advances every cycle.
   - `hsync`=1 only for 656..751.
   - Frame period is 420,000 cycles.
6. **Strobe exclusivity:** over a full frame, assert via checker:
   - `line_stb` and `frame_stb` never high without `pix_stb`.
   - 525 `line_stb` pulses and 1 `frame_stb` pulse per frame.
   - `display_enabled` is high for exactly 307,200 pixel strobes.
